// File: rtl/uart_tx_serializer.sv
// -----------------------------------------------------------------------------
// uart_tx_serializer
//
// Purpose:
//   UART transmit serializer that sits directly after the CPU/UART interface
//   FSM. It waits for the level-held request, then emits one frame. A frame is
//   one start bit (low), NBIT_DATA_LEN data bits LSB first, and a stop period
//   (high). Bit timing comes from the shared oversampling baud strobe. Each
//   completed frame produces a single-cycle done pulse.
//
//   The data byte is captured at the end of the start bit, not when the
//   request arrives. The interface presents data_out one clock after it raises
//   tx_start, so sampling later keeps the frame from carrying a stale byte.
//
// Parameters:
//   NBIT_DATA_LEN  data bits per frame
//   OVERSAMPLE     s_tick pulses per start/data bit
//   SB_TICK        s_tick pulses in the stop period (16 = 1, 24 = 1.5, 32 = 2)
//
// Ports:
//   clk           in   system clock, rising edge
//   reset         in   synchronous, active-high; wins over every other input
//   s_tick        in   baud oversample strobe, one clk wide
//   tx_start      in   level request to send; may stay high across frames
//   din           in   byte to send, sampled at the end of the start bit
//   tx_done_tick  out  one-clk pulse when a frame is complete
//   tx_busy       out  high in every state except IDLE
//   tx            out  registered serial line, idles high
// -----------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int NBIT_DATA_LEN = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int SB_TICK       = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     s_tick,
  input  logic                     tx_start,
  input  logic [NBIT_DATA_LEN-1:0] din,
  output logic                     tx_done_tick,
  output logic                     tx_busy,
  output logic                     tx
);

  // The tick counter must hold the longer of a data-bit period and the stop
  // period. Both counters are cleared explicitly at every phase boundary and
  // never rely on wrapping.
  localparam int TICK_MAX = (OVERSAMPLE > SB_TICK) ? OVERSAMPLE : SB_TICK;
  localparam int TICK_W   = (TICK_MAX > 1) ? $clog2(TICK_MAX) : 1;
  localparam int BIT_W    = (NBIT_DATA_LEN > 1) ? $clog2(NBIT_DATA_LEN) : 1;

  localparam logic [TICK_W-1:0] C_OS_LAST  = TICK_W'(OVERSAMPLE - 1);
  localparam logic [TICK_W-1:0] C_SB_LAST  = TICK_W'(SB_TICK - 1);
  localparam logic [BIT_W-1:0]  C_BIT_LAST = BIT_W'(NBIT_DATA_LEN - 1);
  localparam logic [TICK_W-1:0] C_TICK_ONE = TICK_W'(1);
  localparam logic [BIT_W-1:0]  C_BIT_ONE  = BIT_W'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP,
    S_DONE
  } state_t;

  state_t                   r_state;
  logic [TICK_W-1:0]        r_tick_cnt;
  logic [BIT_W-1:0]         r_bit_cnt;
  logic [NBIT_DATA_LEN-1:0] r_shift;
  logic                     r_tx;
  logic                     r_done;
  logic                     r_busy;

  // Decoded counter boundaries and the shift register's next value.
  logic                     w_os_last;
  logic                     w_sb_last;
  logic                     w_bit_last;
  logic [NBIT_DATA_LEN-1:0] w_shift_next;

  assign w_os_last    = (r_tick_cnt == C_OS_LAST);
  assign w_sb_last    = (r_tick_cnt == C_SB_LAST);
  assign w_bit_last   = (r_bit_cnt == C_BIT_LAST);
  assign w_shift_next = r_shift >> 1;

  // Single-process FSM. tx, tx_busy and tx_done_tick are registered here, so
  // each one is set on the transition into the state that owns its value.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: non-blocking assignments throughout, so every register in this
      // block sees the pre-edge value of every other register.
      r_state    <= S_IDLE;
      r_tick_cnt <= '0;
      r_bit_cnt  <= '0;
      r_shift    <= '0;
      r_tx       <= 1'b1;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      // NOTE: the done pulse gets a default first. Only the end of the stop
      // period overrides it, so it can never last more than one clock.
      r_done <= 1'b0;

      case (r_state)
        // Leaving IDLE does not need s_tick, so the start bit begins on the
        // clock after the request is seen.
        S_IDLE: begin
          r_tx <= 1'b1;
          if (tx_start) begin
            r_state    <= S_START;
            r_tick_cnt <= '0;
            r_bit_cnt  <= '0;
            r_tx       <= 1'b0;
            r_busy     <= 1'b1;
          end
        end

        // Capture din on the last tick of the start bit. The first data bit
        // goes out straight from din so tx stays a pure register.
        S_START: begin
          if (s_tick) begin
            if (w_os_last) begin
              r_state    <= S_DATA;
              r_tick_cnt <= '0;
              r_bit_cnt  <= '0;
              r_shift    <= din;
              r_tx       <= din[0];
            end else begin
              r_tick_cnt <= r_tick_cnt + C_TICK_ONE;
            end
          end
        end

        // Each bit lasts OVERSAMPLE ticks. On a bit boundary, the next value
        // of tx is the bit that is about to land in position 0.
        S_DATA: begin
          if (s_tick) begin
            if (w_os_last) begin
              r_tick_cnt <= '0;
              r_shift    <= w_shift_next;
              if (w_bit_last) begin
                r_state   <= S_STOP;
                r_bit_cnt <= '0;
                r_tx      <= 1'b1;
              end else begin
                r_bit_cnt <= r_bit_cnt + C_BIT_ONE;
                r_tx      <= w_shift_next[0];
              end
            end else begin
              r_tick_cnt <= r_tick_cnt + C_TICK_ONE;
            end
          end
        end

        // The stop period length is set independently, which gives 1, 1.5 or
        // 2 stop bits.
        S_STOP: begin
          r_tx <= 1'b1;
          if (s_tick) begin
            if (w_sb_last) begin
              r_state    <= S_DONE;
              r_tick_cnt <= '0;
              r_done     <= 1'b1;
            end else begin
              r_tick_cnt <= r_tick_cnt + C_TICK_ONE;
            end
          end
        end

        // This state always lasts exactly one clock and ignores tx_start.
        // The gap gives the upstream edge detector time to drop or keep the
        // request before IDLE samples it again.
        S_DONE: begin
          r_state <= S_IDLE;
          r_tx    <= 1'b1;
          r_busy  <= 1'b0;
        end

        // NOTE: the default arm sends any unused state encoding back to IDLE
        // with the line released.
        default: begin
          r_state    <= S_IDLE;
          r_tick_cnt <= '0;
          r_bit_cnt  <= '0;
          r_tx       <= 1'b1;
          r_busy     <= 1'b0;
        end
      endcase
    end
  end

  assign tx           = r_tx;
  assign tx_busy      = r_busy;
  assign tx_done_tick = r_done;

endmodule
